// File: rtl/sensor_packet_spi_slave.sv
// sensor_packet_spi_slave: double-buffered sensor packet source clocked out over an oversampled SPI slave.
// Rev 1.0
`default_nettype none

module sensor_packet_spi_slave #(
    parameter int N_BYTES   = 32,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int OVERWRITE = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sck,
    input  logic                   sdi,
    output logic                   sdo,
    input  logic                   load,
    output logic                   done,
    input  logic [8*N_BYTES-1:0]   data_bytes,
    input  logic                   data_ready,
    output logic                   data_ack,
    output logic                   pkt_sent,
    output logic                   pkt_abort,
    output logic [7:0]             overrun_cnt
);

    localparam int NBITS = 8 * N_BYTES;
    localparam int CW    = $clog2(NBITS + 1);
    localparam int IW    = $clog2(NBITS);
    localparam logic [CW-1:0] FULL = CW'(NBITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READY   = 2'd1,
        SHIFT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [2:0]        sck_s, load_s;
    logic [1:0]        sdi_s;
    logic [NBITS-1:0]  p_buf, p_buf_n, t_buf, t_buf_n;
    logic              p_valid, p_valid_n, t_valid, t_valid_n;
    logic [CW-1:0]     bit_cnt, bit_cnt_n, lch_cnt, lch_cnt_n;
    logic              rel_cnt, rel_cnt_n;
    logic              sdo_n, ack_n, sent_n, abort_n, xfer;
    logic [7:0]        ovr_n;
    logic [IW-1:0]     pos, idx;
    logic              sck_rise, sck_fall, lead_edge, trail_edge;
    logic              sample_edge, launch_edge, load_low, load_rise, edge_en;
    logic              sdi_unused;

    // Sync flops reset to the pin idle levels so release from reset creates no false edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_s  <= {3{CPOL != 0}};
            load_s <= 3'b111;
            sdi_s  <= 2'b00;
        end else begin
            sck_s  <= {sck_s[1:0], sck};
            load_s <= {load_s[1:0], load};
            sdi_s  <= {sdi_s[0], sdi};
        end
    end

    assign sdi_unused  = sdi_s[1];
    assign sck_rise    = sck_s[1] & ~sck_s[2];
    assign sck_fall    = ~sck_s[1] & sck_s[2];
    assign lead_edge   = (CPOL != 0) ? sck_fall : sck_rise;
    assign trail_edge  = (CPOL != 0) ? sck_rise : sck_fall;
    assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
    assign launch_edge = (CPHA != 0) ? lead_edge : trail_edge;
    assign load_low    = ~load_s[1];
    assign load_rise   = load_s[1] & ~load_s[2];
    // Still open on the load-rise cycle so a coincident sample edge is counted first.
    assign edge_en     = ~load_s[1] | ~load_s[2];

    always_comb begin
        state_n   = state;
        p_buf_n   = p_buf;
        p_valid_n = p_valid;
        t_buf_n   = t_buf;
        t_valid_n = t_valid;
        bit_cnt_n = bit_cnt;
        lch_cnt_n = lch_cnt;
        rel_cnt_n = rel_cnt;
        ack_n     = 1'b0;
        sent_n    = 1'b0;
        abort_n   = 1'b0;
        ovr_n     = overrun_cnt;
        sdo_n     = 1'b0;
        pos       = '0;
        idx       = '0;
        xfer      = p_valid && !t_valid;

        if (xfer) begin
            t_buf_n   = p_buf;
            t_valid_n = 1'b1;
            p_valid_n = 1'b0;
        end

        if (data_ready) begin
            if (!p_valid || xfer) begin
                p_buf_n   = data_bytes;
                p_valid_n = 1'b1;
                ack_n     = 1'b1;
            end else if (OVERWRITE != 0) begin
                p_buf_n = data_bytes;
                ack_n   = 1'b1;
                if (overrun_cnt != 8'hFF) ovr_n = overrun_cnt + 8'd1;
            end
        end

        case (state)
            IDLE: begin
                if (t_valid) state_n = READY;
            end
            READY: begin
                bit_cnt_n = '0;
                lch_cnt_n = '0;
                if (load_rise) begin
                    state_n   = RELEASE;
                    rel_cnt_n = 1'b0;
                    abort_n   = 1'b1;
                end else if (load_low) begin
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (edge_en && sample_edge && bit_cnt != FULL) bit_cnt_n = bit_cnt + CW'(1);
                if (edge_en && launch_edge && lch_cnt != FULL) lch_cnt_n = lch_cnt + CW'(1);
                if (load_rise) begin
                    state_n   = RELEASE;
                    rel_cnt_n = 1'b0;
                    if (bit_cnt_n == FULL) begin
                        sent_n    = 1'b1;
                        t_valid_n = 1'b0;
                    end else begin
                        abort_n = 1'b1;
                    end
                end
            end
            RELEASE: begin
                rel_cnt_n = 1'b1;
                if (rel_cnt) state_n = t_valid ? READY : IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Linear bit k maps to byte k/8, bit 7-(k%8); CPHA=1 presents bit k after the (k+1)th leading edge.
        pos = (CPHA != 0) ? IW'(lch_cnt_n - CW'(1)) : IW'(lch_cnt_n);
        idx = {pos[IW-1:3], ~pos[2:0]};
        if (state_n == SHIFT && load_low && bit_cnt_n != FULL &&
            (CPHA == 0 || lch_cnt_n != '0)) begin
            sdo_n = t_buf[idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            p_buf       <= '0;
            p_valid     <= 1'b0;
            t_buf       <= '0;
            t_valid     <= 1'b0;
            bit_cnt     <= '0;
            lch_cnt     <= '0;
            rel_cnt     <= 1'b0;
            sdo         <= 1'b0;
            done        <= 1'b0;
            data_ack    <= 1'b0;
            pkt_sent    <= 1'b0;
            pkt_abort   <= 1'b0;
            overrun_cnt <= 8'd0;
        end else begin
            state       <= state_n;
            p_buf       <= p_buf_n;
            p_valid     <= p_valid_n;
            t_buf       <= t_buf_n;
            t_valid     <= t_valid_n;
            bit_cnt     <= bit_cnt_n;
            lch_cnt     <= lch_cnt_n;
            rel_cnt     <= rel_cnt_n;
            sdo         <= sdo_n;
            done        <= t_valid && (state != RELEASE);
            data_ack    <= ack_n;
            pkt_sent    <= sent_n;
            pkt_abort   <= abort_n;
            overrun_cnt <= ovr_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sensor_packet_spi_slave.sv
// tb_sensor_packet_spi_slave: mode-0/N=32/no-overwrite and mode-3/N=4/overwrite instances against a packet-level model.
// Rev 1.0
`default_nettype none

module tb_sensor_packet_spi_slave;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [1:0]   sck_p, load_p, dr;
    logic         sdi_p;
    logic [1:0]   sdo_w, done_w, ack_w, sent_w, abort_w;
    logic [7:0]   ovr0, ovr1;
    logic [255:0] data0;
    logic [31:0]  data1;

    sensor_packet_spi_slave #(.N_BYTES(32), .CPOL(0), .CPHA(0), .OVERWRITE(0)) u0 (
        .clk(clk), .reset(reset), .sck(sck_p[0]), .sdi(sdi_p), .sdo(sdo_w[0]),
        .load(load_p[0]), .done(done_w[0]), .data_bytes(data0), .data_ready(dr[0]),
        .data_ack(ack_w[0]), .pkt_sent(sent_w[0]), .pkt_abort(abort_w[0]), .overrun_cnt(ovr0));

    sensor_packet_spi_slave #(.N_BYTES(4), .CPOL(1), .CPHA(1), .OVERWRITE(1)) u1 (
        .clk(clk), .reset(reset), .sck(sck_p[1]), .sdi(sdi_p), .sdo(sdo_w[1]),
        .load(load_p[1]), .done(done_w[1]), .data_bytes(data1), .data_ready(dr[1]),
        .data_ack(ack_w[1]), .pkt_sent(sent_w[1]), .pkt_abort(abort_w[1]), .overrun_cnt(ovr1));

    int errors = 0;
    int checks = 0;

    // Packet-level model: up to two packets held per DUT, in delivery order.
    logic [255:0] m_pkt [2][2];
    int           m_cnt [2];
    bit           m_pend [2];
    logic [255:0] m_pend_pkt [2];
    int           exp_ack [2], exp_sent [2], exp_abort [2];
    int           ack_n [2], sent_n [2], abort_n [2];
    int           lh [2];
    logic [1:0]   p_ack, p_sent, p_abort;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input int id);
        return (id == 0) ? 32 : 4;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_push(input int id, input logic [255:0] p);
        logic [255:0] q;
        q = (id == 1) ? {224'b0, p[31:0]} : p;
        if (m_cnt[id] < 2) begin
            m_pkt[id][m_cnt[id]] = q;
            m_cnt[id]++;
            exp_ack[id]++;
        end else if (id == 1) begin
            m_pkt[id][1] = q;
            exp_ack[id]++;
        end else begin
            m_pend[id]     = 1'b1;
            m_pend_pkt[id] = q;
        end
    endtask

    task automatic model_pop(input int id);
        m_pkt[id][0] = m_pkt[id][1];
        m_cnt[id]--;
        exp_sent[id]++;
        if (m_pend[id]) begin
            m_pend[id] = 1'b0;
            model_push(id, m_pend_pkt[id]);
        end
    endtask

    task automatic set_data(input int id, input logic [255:0] p);
        if (id == 0) data0 = p;
        else data1 = p[31:0];
    endtask

    task automatic offer(input int id, input logic [255:0] p);
        set_data(id, p);
        dr[id] = 1'b1;
        @(negedge clk);
        dr[id] = 1'b0;
        model_push(id, p);
        repeat (6) @(negedge clk);
    endtask

    task automatic mcu_begin(input int id);
        load_p[id] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Each bit: half period of 5 clk, sample just before the sample edge.
    task automatic mcu_bits(input int id, input int n, inout logic [255:0] rx);
        int k;
        for (k = 0; k < n; k++) begin
            repeat (5) @(negedge clk);
            if (id == 0) rx[8*(k/8) + 7 - (k%8)] = sdo_w[id];
            sck_p[id] = ~sck_p[id];
            repeat (5) @(negedge clk);
            if (id == 1) rx[8*(k/8) + 7 - (k%8)] = sdo_w[id];
            sck_p[id] = ~sck_p[id];
        end
    endtask

    task automatic mcu_end(input int id, output int lowcnt);
        repeat (5) @(negedge clk);
        load_p[id] = 1'b1;
        lowcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (!done_w[id]) lowcnt++;
        end
    endtask

    task automatic full_read(input int id, input string name, output logic [255:0] rx);
        int lowcnt;
        logic [255:0] exp_p;
        rx = '0;
        mcu_begin(id);
        mcu_bits(id, 8 * nbytes(id), rx);
        mcu_end(id, lowcnt);
        exp_p = m_pkt[id][0];
        chk({name, "_data"}, rx, exp_p);
        model_pop(id);
        chk({name, "_sent"}, sent_n[id], exp_sent[id]);
        if (m_cnt[id] > 0) begin
            chk({name, "_done_low_cycles"}, lowcnt, 2);
            chk({name, "_done_again"}, done_w[id], 1);
        end else begin
            chk({name, "_done_clear"}, done_w[id], 0);
        end
    endtask

    // Per-cycle invariants: one-cycle pulses, idle MISO, pulse tallies.
    always @(negedge clk) begin
        if (reset) begin
            p_ack = 0; p_sent = 0; p_abort = 0;
            lh[0] = 0; lh[1] = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ack_w[i])   begin ack_n[i]++;   chk("ack_one_cycle",   p_ack[i],   0); end
                if (sent_w[i])  begin sent_n[i]++;  chk("sent_one_cycle",  p_sent[i],  0); end
                if (abort_w[i]) begin abort_n[i]++; chk("abort_one_cycle", p_abort[i], 0); end
                lh[i] = load_p[i] ? lh[i] + 1 : 0;
                if (lh[i] >= 4) chk("sdo_zero_load_high", sdo_w[i], 0);
            end
            p_ack = ack_w; p_sent = sent_w; p_abort = abort_w;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] p, x, y, z, rx;
        int lowcnt;
        for (int i = 0; i < 2; i++) begin
            exp_ack[i] = 0; exp_sent[i] = 0; exp_abort[i] = 0;
            ack_n[i] = 0; sent_n[i] = 0; abort_n[i] = 0; lh[i] = 0;
        end
        model_clear();
        load_p = 2'b11; sck_p = 2'b10; dr = 2'b00; sdi_p = 1'b0;
        data0 = '0; data1 = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_sdo", sdo_w[i], 0);
            chk("rst_done", done_w[i], 0);
            chk("rst_ack", ack_w[i], 0);
            chk("rst_sent", sent_w[i], 0);
            chk("rst_abort", abort_w[i], 0);
        end
        chk("rst_ovr0", ovr0, 0);
        chk("rst_ovr1", ovr1, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Mode 0, bytes 0x00..0x1F, latency pinned by hand.
        for (int i = 0; i < 32; i++) p[8*i +: 8] = 8'(i);
        set_data(0, p);
        dr[0] = 1'b1;
        @(negedge clk);
        dr[0] = 1'b0;
        chk("ack_latency", ack_w[0], 1);
        model_push(0, p);
        @(negedge clk);
        chk("ack_pulse", ack_w[0], 0);
        chk("done_not_yet", done_w[0], 0);
        @(negedge clk);
        chk("done_latency", done_w[0], 1);
        repeat (4) @(negedge clk);
        full_read(0, "mode0", rx);
        chk("mode0_byte1", rx[15:8], 8'h01);
        chk("mode0_byte31", rx[255:248], 8'h1F);

        // CPOL=1 CPHA=1, N=4.
        offer(1, 256'hF00F3CA5);
        repeat (4) @(negedge clk);
        full_read(1, "mode3", rx);
        chk("mode3_literal", rx[31:0], 32'hF00F3CA5);

        // Back-pressure with OVERWRITE=0.
        for (int i = 0; i < 32; i++) begin
            x[8*i +: 8] = 8'h40 + 8'(i);
            y[8*i +: 8] = 8'h80 ^ 8'(i);
            z[8*i +: 8] = ~8'(i);
        end
        offer(0, x);
        offer(0, y);
        chk("bp_xy_acked", ack_n[0], exp_ack[0]);
        set_data(0, z);
        dr[0] = 1'b1;
        model_push(0, z);
        repeat (20) @(negedge clk);
        chk("bp_z_held", ack_n[0], exp_ack[0]);
        chk("bp_done", done_w[0], 1);
        full_read(0, "bp_x", rx);
        chk("bp_z_acked", ack_n[0], exp_ack[0]);
        dr[0] = 1'b0;
        full_read(0, "bp_y", rx);
        full_read(0, "bp_z", rx);
        chk("bp_ovr", ovr0, 0);

        // OVERWRITE=1: Z replaces pending Y.
        offer(1, 256'h11223344);
        offer(1, 256'h55667788);
        offer(1, 256'h99AABBCC);
        chk("ow_acks", ack_n[1], exp_ack[1]);
        chk("ow_overrun", ovr1, 1);
        full_read(1, "ow_x", rx);
        full_read(1, "ow_z", rx);
        chk("ow_z_literal", rx[31:0], 32'h99AABBCC);

        // Abort after 100 bits, then re-read from byte 0.
        for (int i = 0; i < 32; i++) p[8*i +: 8] = 8'h5A ^ 8'(i * 3);
        offer(0, p);
        rx = '0;
        mcu_begin(0);
        mcu_bits(0, 100, rx);
        mcu_end(0, lowcnt);
        exp_abort[0]++;
        chk("abort_pulse", abort_n[0], exp_abort[0]);
        chk("abort_no_sent", sent_n[0], exp_sent[0]);
        chk("abort_done_again", done_w[0], 1);
        chk("abort_done_low", lowcnt, 2);
        chk("abort_partial", rx[95:0], p[95:0]);
        full_read(0, "after_abort", rx);

        // Reset in the middle of a transfer at bit 37.
        offer(0, {256{1'b1}});
        rx = '0;
        mcu_begin(0);
        mcu_bits(0, 37, rx);
        repeat (4) @(negedge clk);
        chk("pre_reset_sdo", sdo_w[0], 1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_sdo", sdo_w[0], 0);
        chk("mid_rst_done", done_w[0], 0);
        chk("mid_rst_ovr0", ovr0, 0);
        chk("mid_rst_ovr1", ovr1, 0);
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        load_p[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_done", done_w[0], 0);
        for (int i = 0; i < 32; i++) p[8*i +: 8] = 8'h3C + 8'(i * 5);
        offer(0, p);
        full_read(0, "post_reset", rx);

        for (int i = 0; i < 2; i++) begin
            chk("total_acks", ack_n[i], exp_ack[i]);
            chk("total_sent", sent_n[i], exp_sent[i]);
            chk("total_abort", abort_n[i], exp_abort[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
